// File: rtl/bm_trig_pkg.sv
// Shared types, default parameters and width helper for the beam-monitor coincidence trigger.
package bm_trig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 48;
    localparam int DEF_MULT_W     = 5;
    localparam int DEF_TRIG_WIDTH = 4;
    localparam int DEF_DEADTIME   = 16;
    localparam int DEF_CNT_WIDTH  = 32;
    localparam int PSC_W          = 8;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int bm_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/bm_popcount.sv
// Combinational population count of the per-bar coincidence vector.
module bm_popcount #(
    parameter int NBARS  = 24,
    parameter int MULT_W = 5
) (
    input  logic [NBARS-1:0]  bits,
    output logic [MULT_W-1:0] count
);

    // NOTE: inside always_comb, blocking '=' is correct and every output gets a
    // default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        count = '0;
        for (int i = 0; i < NBARS; i++) begin
            count = count + MULT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/bm_coinc_trigger.sv
// Bar end-to-end coincidence, multiplicity threshold trigger with fixed width and dead time.
// Optional BM_PRESCALE_EN adds a prescale input that issues every (prescale+1)-th candidate.
module bm_coinc_trigger
    import bm_trig_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MULT_W     = DEF_MULT_W,
    parameter int TRIG_WIDTH = DEF_TRIG_WIDTH,
    parameter int DEADTIME   = DEF_DEADTIME,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     hits,
    input  logic [MULT_W-1:0]    mult_thresh,
`ifdef BM_PRESCALE_EN
    input  logic [PSC_W-1:0]     prescale,
`endif
    output logic                 trig_out,
    output logic [WIDTH/2-1:0]   pattern_out,
    output logic                 pattern_valid,
    output logic [MULT_W-1:0]    mult_out,
    output logic [CNT_WIDTH-1:0] trig_count,
    output logic                 busy
);

    localparam int NBARS   = WIDTH / 2;
    localparam int TMR_MAX = (TRIG_WIDTH > DEADTIME) ? TRIG_WIDTH : DEADTIME;
    localparam int TMR_W   = bm_clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] FIRE_LAST = TMR_W'(TRIG_WIDTH - 1);
    localparam logic [TMR_W-1:0] DEAD_LAST = (DEADTIME > 0) ? TMR_W'(DEADTIME - 1) : '0;

    logic [NBARS-1:0]  coinc_d;
    logic [NBARS-1:0]  coinc_q;
    logic [NBARS-1:0]  pat_q;
    logic [MULT_W-1:0] mult_d;
    logic [MULT_W-1:0] mult_q;

    state_t            state;
    state_t            state_next;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_next;
    logic              candidate;
    logic              fire_start;

    // Stage 1: a bar counts only when both PMT ends fire in the same cycle.
    always_comb begin
        coinc_d = '0;
        for (int i = 0; i < NBARS; i++) begin
            coinc_d[i] = hits[2*i] & hits[2*i+1];
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coinc_q <= '0;
        end else begin
            coinc_q <= coinc_d;
        end
    end

    bm_popcount #(
        .NBARS  (NBARS),
        .MULT_W (MULT_W)
    ) u_popcount (
        .bits  (coinc_q),
        .count (mult_d)
    );

    // Stage 2: multiplicity and pattern travel together into the FSM stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_q <= '0;
            pat_q  <= '0;
        end else begin
            mult_q <= mult_d;
            pat_q  <= coinc_q;
        end
    end

    // A zero threshold is treated as "trigger off" rather than "always fire".
    assign candidate = enable && (mult_thresh != '0) && (mult_q >= mult_thresh);

`ifdef BM_PRESCALE_EN
    logic [PSC_W-1:0] psc_cnt;
    logic [PSC_W-1:0] psc_next;
`endif

    // Stage 3: FSM next state; candidates outside IDLE are simply ignored.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        fire_start = 1'b0;
`ifdef BM_PRESCALE_EN
        psc_next   = psc_cnt;
`endif
        case (state)
            IDLE: begin
                if (candidate) begin
`ifdef BM_PRESCALE_EN
                    if (psc_cnt == prescale) begin
                        fire_start = 1'b1;
                        psc_next   = '0;
                    end else begin
                        psc_next   = psc_cnt + 1'b1;
                    end
`else
                    fire_start = 1'b1;
`endif
                end
                if (fire_start) begin
                    state_next = FIRE;
                    tmr_next   = '0;
                end
            end
            FIRE: begin
                if (tmr == FIRE_LAST) begin
                    tmr_next   = '0;
                    state_next = (DEADTIME == 0) ? IDLE : DEAD;
                end else begin
                    tmr_next   = tmr + 1'b1;
                end
            end
            DEAD: begin
                if (tmr == DEAD_LAST) begin
                    tmr_next   = '0;
                    state_next = IDLE;
                end else begin
                    tmr_next   = tmr + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tmr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

`ifdef BM_PRESCALE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_next;
        end
    end
`endif

    // Outputs are registered from the next state so they line up with the state flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_out      <= 1'b0;
            busy          <= 1'b0;
            pattern_valid <= 1'b0;
            pattern_out   <= '0;
            mult_out      <= '0;
            trig_count    <= '0;
        end else begin
            trig_out      <= (state_next == FIRE);
            busy          <= (state_next != IDLE);
            pattern_valid <= fire_start;
            if (fire_start) begin
                pattern_out <= pat_q;
                mult_out    <= mult_q;
                if (trig_count != '1) begin
                    trig_count <= trig_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_coinc_trigger.sv
// Directed self-checking bench for bm_coinc_trigger (default parameters).
// Define BM_PRESCALE_EN for both RTL and bench to include the prescale scenario.
module tb_bm_coinc_trigger;

    localparam logic [47:0] EV3    = 48'hC000_0000_0033;  // bars 0, 2, 23
    localparam logic [47:0] SINGLE = 48'h0000_0000_0015;  // one end of bars 0, 1, 2
    localparam logic [47:0] BAR10  = 48'h0000_0030_0000;  // both ends of bar 10
    localparam logic [47:0] ALL    = {48{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [47:0] hits = '0;
    logic [4:0]  mult_thresh = '0;
`ifdef BM_PRESCALE_EN
    logic [7:0]  prescale = '0;
`endif
    logic        trig_out;
    logic [23:0] pattern_out;
    logic        pattern_valid;
    logic [4:0]  mult_out;
    logic [31:0] trig_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int pv_count = 0;

    bm_coinc_trigger dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .hits          (hits),
        .mult_thresh   (mult_thresh),
`ifdef BM_PRESCALE_EN
        .prescale      (prescale),
`endif
        .trig_out      (trig_out),
        .pattern_out   (pattern_out),
        .pattern_valid (pattern_valid),
        .mult_out      (mult_out),
        .trig_count    (trig_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && pattern_valid) pv_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present v for exactly one cycle (cycle N); returns in cycle N+1.
    task automatic pulse(input logic [47:0] v);
        hits = v;
        tick(1);
        hits = '0;
    endtask

    initial begin
        int quiet_err;
        int trig_err;
        int pv_err;
        int busy_err;

        // Reset values.
        tick(3);
        check("rst_trig", trig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pv", pattern_valid, 0);
        check("rst_count", trig_count, 0);
        check("rst_pattern", pattern_out, 0);
        check("rst_mult", mult_out, 0);

        reset = 1'b0;
        enable = 1'b1;
        mult_thresh = 5'd2;
        quiet_err = 0;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (trig_out || busy || pattern_valid || trig_count != 0) quiet_err++;
        end
        check("idle_quiet", quiet_err, 0);

        // Three-bar coincidence: trigger window N+3..N+6, busy through N+22.
        trig_err = 0; pv_err = 0; busy_err = 0;
        pulse(EV3);
        for (int k = 1; k <= 24; k++) begin
            if (trig_out !== (k >= 3 && k <= 6)) trig_err++;
            if (pattern_valid !== (k == 3)) pv_err++;
            if (busy !== (k >= 3 && k <= 22)) busy_err++;
            if (k == 3) begin
                check("ev3_pattern", pattern_out, 24'h80_0005);
                check("ev3_mult", mult_out, 3);
                check("ev3_count", trig_count, 1);
            end
            tick(1);
        end
        check("ev3_trig_window", trig_err, 0);
        check("ev3_pv_window", pv_err, 0);
        check("ev3_busy_window", busy_err, 0);
        check("ev3_hold_pattern", pattern_out, 24'h80_0005);

        // Single ends never count, even with threshold 1.
        mult_thresh = 5'd1;
        pulse(SINGLE);
        tick(10);
        check("single_end_count", trig_count, 1);

        // Threshold 1 fires on one full bar.
        pulse(BAR10);
        tick(2);
        check("thr1_trig", trig_out, 1);
        check("thr1_mult", mult_out, 1);
        check("thr1_pattern", pattern_out, 24'h00_0400);
        tick(25);

        // Threshold 0 and threshold above NBARS never fire.
        mult_thresh = 5'd0;
        pulse(ALL);
        tick(10);
        check("thr0_count", trig_count, 2);
        mult_thresh = 5'd25;
        pulse(ALL);
        tick(10);
        check("thr25_count", trig_count, 2);

        // Threshold equal to NBARS fires on all bars.
        mult_thresh = 5'd24;
        pulse(ALL);
        tick(2);
        check("thr24_trig", trig_out, 1);
        check("thr24_mult", mult_out, 24);
        check("thr24_pattern", pattern_out, 24'hFF_FFFF);
        tick(25);

        // Disabled: no new trigger.
        mult_thresh = 5'd2;
        enable = 1'b0;
        pulse(EV3);
        tick(10);
        check("disabled_count", trig_count, 3);
        enable = 1'b1;

        // Second event 10 cycles later falls in FIRE/DEAD and is dropped.
        pulse(EV3);
        tick(9);
        pulse(EV3);
        tick(30);
        check("veto10_count", trig_count, 4);

        // Second event 21 cycles later arrives as the FSM returns to IDLE.
        pulse(EV3);
        tick(20);
        pulse(EV3);
        tick(2);
        check("gap21_trig", trig_out, 1);
        check("gap21_count", trig_count, 6);
        tick(25);

        // Asynchronous reset in the middle of FIRE.
        pulse(EV3);
        tick(3);
        check("midfire_trig", trig_out, 1);
        reset = 1'b1;
        #1;
        check("async_trig", trig_out, 0);
        check("async_busy", busy, 0);
        check("async_count", trig_count, 0);
        check("async_mult", mult_out, 0);
        tick(2);
        reset = 1'b0;
        tick(10);
        check("post_rst_trig", trig_out, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_count", trig_count, 0);
        pulse(EV3);
        tick(2);
        check("post_rst_fire", trig_out, 1);
        check("post_rst_count1", trig_count, 1);
        tick(25);
        check("pv_total", pv_count, 8);

`ifdef BM_PRESCALE_EN
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        prescale = 8'd2;
        tick(2);
        trig_err = 0;
        for (int e = 1; e <= 9; e++) begin
            pulse(EV3);
            tick(2);
            if (trig_out !== (e % 3 == 0)) trig_err++;
            tick(27);
        end
        check("psc_pattern", trig_err, 0);
        check("psc_count", trig_count, 3);
        check("psc_pv_total", pv_count, 11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bm_coinc_trigger.md
Name: bm_coinc_trigger

Overview:
- Sits directly downstream of the per-channel lead-edge delay stage on the small beam-monitor bars.
- Consumes its WIDTH-bit delayed lead pulses, where channel pair (2i, 2i+1) is the two PMT ends of bar i.
- Forms per-bar end-to-end coincidences and computes bar multiplicity.
- Issues a fixed-width trigger when multiplicity reaches a run-time threshold, followed by a programmable dead time. Latches the bar hit pattern and counts issued triggers.

Parameters:
- WIDTH, 48, number of input channels; must be even; NBARS = WIDTH/2.
- MULT_W, 5, width of multiplicity and threshold; must satisfy 2**MULT_W > NBARS.
- TRIG_WIDTH, 4, clock cycles trig_out stays high; must be >= 1.
- DEADTIME, 16, clock cycles of veto after trig_out falls; 0 is allowed.
- CNT_WIDTH, 32, width of the trigger counter.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- enable, in, 1, arms the trigger; when low, no new trigger is started.
- hits, in, WIDTH, delayed lead pulses from the upstream delay stage.
- mult_thresh, in, MULT_W, minimum coincident bars for a trigger; quasi-static.
- trig_out, out, 1, trigger pulse.
- pattern_out, out, NBARS, bar coincidence pattern of the triggering event.
- pattern_valid, out, 1, one-cycle strobe when pattern_out updates.
- mult_out, out, MULT_W, multiplicity of the triggering event.
- trig_count, out, CNT_WIDTH, number of issued triggers; saturating.
- busy, out, 1, high while in FIRE or DEAD.

Behaviour:
- Reset (asynchronous, active-high): all pipeline registers, trig_out, pattern_out, pattern_valid, mult_out, trig_count and busy go to 0; FSM goes to IDLE. Reset may assert at any cycle, including mid-FIRE or mid-DEAD; release resumes in IDLE with an empty pipeline.
- Stage 1 (edge 1): coinc_q[i] <= hits[2i] & hits[2i+1].
- Stage 2 (edge 2): mult_q <= popcount(coinc_q); pat_q <= coinc_q.
- Stage 3 (edge 3): FSM evaluates. The candidate condition is enable & (mult_thresh != 0) & (mult_q >= mult_thresh).
- Latency: hits presented in cycle N produce trig_out high from cycle N+3.
- FSM states: IDLE, FIRE, DEAD.
  - IDLE -> FIRE on a candidate. On this transition: trig_out <= 1, pattern_out <= pat_q, mult_out <= mult_q, pattern_valid pulses for one cycle, trig_count increments.
  - FIRE holds TRIG_WIDTH cycles, then goes to DEAD (or to IDLE if DEADTIME == 0). trig_out clears on exit.
  - DEAD holds DEADTIME cycles, then goes to IDLE.
- busy = (state != IDLE), registered.
- The pipeline runs continuously. Candidates arriving while in FIRE or DEAD are discarded, not queued. The first cycle in IDLE may fire on the candidate present at that time.
- enable deassertion does not abort FIRE or DEAD; only new triggers are blocked.
- Threshold rules:
  - mult_thresh == 0 never fires.
  - mult_thresh > NBARS never fires.
  - mult_thresh == 1 fires on any single-bar coincidence.
- A single end hit (one channel of a pair) never counts toward multiplicity.
- trig_count saturates at all-ones; no wrap.
- pattern_out and mult_out hold their values until the next issued trigger.

Optional Feature:
- Macro: BM_PRESCALE_EN.
- Defined:
  - Adds input port prescale [7:0].
  - An 8-bit candidate counter selects which candidates issue: the candidate when count == prescale issues (enters FIRE) and the counter clears; all other candidates increment the counter and are dropped.
  - Dropped candidates do not enter FIRE or DEAD, do not strobe pattern_valid and do not increment trig_count.
  - prescale == 0 means every candidate issues.
  - The counter is cleared by reset.
- Not defined: port absent; every candidate issues.

Decomposition:
- Package bm_trig_pkg holds:
  - state enum typedef {IDLE, FIRE, DEAD};
  - default parameter constants;
  - a clog2 helper for counter widths.
- One sub-module, bm_popcount: parameterised NBARS-to-MULT_W combinational population count, registered in the parent as stage 2.

Test Plan:
- Reset and static low: hold reset, then release with hits = 0 for 50 cycles -> all outputs 0, busy 0.
- Three-bar coincidence: mult_thresh = 2; one cycle hits set bits 0,1,4,5,46,47 -> trig_out high exactly cycles N+3..N+6, pattern_out = bars 0,2,23 set, mult_out = 3, pattern_valid one pulse at N+3, trig_count = 1, busy low at N+23.
- Single ends and threshold: hits bits 0,2,4 only -> no trigger. mult_thresh = 0 with all 48 bits high -> no trigger. mult_thresh = 25 with all 48 bits high -> no trigger.
- Dead-time veto: two qualifying events 10 cycles apart -> one trigger. Two events 21 cycles apart -> two triggers, trig_count = 2.
- Reset mid-FIRE: assert reset at N+4 -> trig_out drops asynchronously. After release with hits = 0 -> IDLE, trig_count = 0.
- BM_PRESCALE_EN: prescale = 2; 9 qualifying events spaced 30 cycles apart -> exactly 3 triggers (events 3, 6, 9), trig_count = 3.
